// File: rtl/mult_seq_responder_pkg.sv
// Shared multiplier definitions: opcode encoding, signedness encodings, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mult_seq_responder_pkg;

    localparam int MUL_OP_WIDTH = 3;

    typedef enum logic [MUL_OP_WIDTH-1:0] {
        MUL_MAC32 = 3'b000,
        MUL_H     = 3'b110
    } mul_opcode_e;

    // short_signed encodings: bit 0 = op_a signed, bit 1 = op_b signed
    localparam logic [1:0] SS_MULH   = 2'b11;
    localparam logic [1:0] SS_MULHSU = 2'b01;
    localparam logic [1:0] SS_MULHU  = 2'b00;

    function automatic logic op_is_legal(input logic [MUL_OP_WIDTH-1:0] op);
        return (op == MUL_MAC32) || (op == MUL_H);
    endfunction

    // Magnitude of a 32-bit value; -2^31 maps to 0x80000000 as unsigned
    function automatic logic [31:0] magnitude(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_seq_step.sv
// One shift-add step: 32 x BITS_PER_CYCLE partial product added into a 64-bit accumulator.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module mult_seq_step #(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [63:0]               acc,
    input  logic [31:0]               mag_a,
    input  logic [BITS_PER_CYCLE-1:0] digit,
    input  logic [4:0]                count,
    output logic [63:0]               acc_next
);

    logic [31+BITS_PER_CYCLE:0] pp;
    logic [63:0]                pp_ext;
    logic [5:0]                 shamt;

    // Partial product placed at bit offset count*BITS_PER_CYCLE, then accumulated
    always_comb begin
        pp       = {{BITS_PER_CYCLE{1'b0}}, mag_a} * {32'd0, digit};
        shamt    = 6'(count) * 6'(BITS_PER_CYCLE);
        pp_ext   = 64'(pp) << shamt;
        acc_next = acc + pp_ext;
    end

endmodule

// File: rtl/mult_seq_responder.sv
// Iterative MUL/MULH responder (radix 2^BITS_PER_CYCLE); MULT_FAST_LOW_EN adds a one-cycle MUL path.
// Latency: STEPS+1 cycles from accept to ready_o (1 cycle for MUL with MULT_FAST_LOW_EN).
// Backpressure: result held in DONE until ex_ready_i; new requests taken only in IDLE.
module mult_seq_responder
    import mult_seq_responder_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [MUL_OP_WIDTH-1:0] operator_i,
    input  logic [1:0]              short_signed_i,
    input  logic [31:0]             op_a_i,
    input  logic [31:0]             op_b_i,
    input  logic                    ex_ready_i,
    output logic [31:0]             result_o,
    output logic                    ready_o,
    output logic                    multicycle_o
);

    localparam int         STEPS     = 32 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg;
    logic        is_mulh;
    logic [63:0] acc;
    logic [4:0]  count;

    logic [63:0] acc_next;
    logic [63:0] prod;
    logic        sign_a;
    logic        sign_b;
    logic        take_fast;
    logic [31:0] fast_low;

    assign sign_a = short_signed_i[0] & op_a_i[31];
    assign sign_b = short_signed_i[1] & op_b_i[31];

    // Product magnitude is below 2^63, so the negation never overflows
    assign prod = neg ? (~acc_next + 64'd1) : acc_next;

`ifdef MULT_FAST_LOW_EN
    // Low word of a*b is sign-agnostic, so MUL can finish in the accept cycle
    assign take_fast = (operator_i == MUL_MAC32);
    assign fast_low  = op_a_i * op_b_i;
`else
    assign take_fast = 1'b0;
    assign fast_low  = 32'd0;
`endif

    mult_seq_step #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc      (acc),
        .mag_a    (mag_a),
        .digit    (mag_b[BITS_PER_CYCLE-1:0]),
        .count    (count),
        .acc_next (acc_next)
    );

    // Handshake outputs derived directly from state
    assign ready_o      = ((state == IDLE) && !enable_i) || (state == DONE);
    assign multicycle_o = (state == CALC);

    // Control FSM and shift-add datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mag_a    <= 32'd0;
            mag_b    <= 32'd0;
            neg      <= 1'b0;
            is_mulh  <= 1'b0;
            acc      <= 64'd0;
            count    <= 5'd0;
            result_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        if (!op_is_legal(operator_i)) begin
                            result_o <= 32'd0;
                            state    <= DONE;
                        end else if (take_fast) begin
                            result_o <= fast_low;
                            state    <= DONE;
                        end else begin
                            mag_a   <= magnitude(sign_a, op_a_i);
                            mag_b   <= magnitude(sign_b, op_b_i);
                            neg     <= sign_a ^ sign_b;
                            is_mulh <= (operator_i == MUL_H);
                            acc     <= 64'd0;
                            count   <= 5'd0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mag_b <= mag_b >> BITS_PER_CYCLE;
                    count <= count + 5'd1;
                    if (count == LAST_STEP) begin
                        result_o <= is_mulh ? prod[63:32] : prod[31:0];
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (ex_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_responder.sv
// Directed bench for mult_seq_responder: results, latency, hold, reset and width sweep.
// Latency: MUL expectations follow MULT_FAST_LOW_EN when it is defined for the build.
// Backpressure: exercises DONE hold with ex_ready_i low and back-to-back requests.
module tb_mult_seq_responder;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_MULH = 3'b110;
    localparam logic [2:0] OP_BAD  = 3'b001;
`ifdef MULT_FAST_LOW_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 17;
`endif
    localparam int MULH_LAT = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        ex_ready = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [1:0]  ss = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;

    logic [31:0] res1, res2, res4, res8;
    logic        rdy1, rdy2, rdy4, rdy8;
    logic        mc1, mc2, mc4, mc8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_seq_responder #(.BITS_PER_CYCLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op),
        .short_signed_i(ss), .op_a_i(a), .op_b_i(b), .ex_ready_i(ex_ready),
        .result_o(res2), .ready_o(rdy2), .multicycle_o(mc2)
    );
    mult_seq_responder #(.BITS_PER_CYCLE(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op),
        .short_signed_i(ss), .op_a_i(a), .op_b_i(b), .ex_ready_i(ex_ready),
        .result_o(res1), .ready_o(rdy1), .multicycle_o(mc1)
    );
    mult_seq_responder #(.BITS_PER_CYCLE(4)) dut_b4 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op),
        .short_signed_i(ss), .op_a_i(a), .op_b_i(b), .ex_ready_i(ex_ready),
        .result_o(res4), .ready_o(rdy4), .multicycle_o(mc4)
    );
    mult_seq_responder #(.BITS_PER_CYCLE(8)) dut_b8 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op),
        .short_signed_i(ss), .op_a_i(a), .op_b_i(b), .ex_ready_i(ex_ready),
        .result_o(res8), .ready_o(rdy8), .multicycle_o(mc8)
    );

    // Issue one request to an idle DUT and wait (bounded) for ready_o
    task automatic run_op(input logic [2:0] o, input logic [1:0] s,
                          input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic [31:0] r);
        @(negedge clk);
        op = o; ss = s; a = x; b = y; enable = 1'b1; ex_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        lat = 1;
        while (!rdy2 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = res2;
    endtask

    task automatic release_done;
        @(negedge clk);
        ex_ready = 1'b1;
        @(negedge clk);
        ex_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rdy2); end
        checks++; if (res2 !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", res2); end
        checks++; if (mc2 !== 1'b0) begin errors++; $display("FAIL reset_multicycle: got %b expected 0", mc2); end
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        int lat; logic [31:0] r;
        run_op(OP_MUL, 2'b00, 32'd7, 32'd6, lat, r);
        checks++; if (r !== 32'h0000002A) begin errors++; $display("FAIL mul_7x6: got %h expected 0000002a", r); end
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_latency: got %0d expected %0d", lat, MUL_LAT); end
        release_done();
    endtask

    task automatic test_mulh;
        logic [1:0]  vs [4] = '{2'b11, 2'b11, 2'b01, 2'b00};
        logic [31:0] va [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vb [4] = '{32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ve [4] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        int lat; logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            run_op(OP_MULH, vs[i], va[i], vb[i], lat, r);
            checks++; if (r !== ve[i]) begin errors++; $display("FAIL mulh_vec%0d: got %h expected %h", i, r, ve[i]); end
            checks++; if (lat !== MULH_LAT) begin errors++; $display("FAIL mulh_latency%0d: got %0d expected %0d", i, lat, MULH_LAT); end
            release_done();
        end
    endtask

    task automatic test_hold_and_back_to_back;
        int lat; logic [31:0] r;
        run_op(OP_MULH, 2'b11, 32'hFFFFFFFF, 32'h00000002, lat, r);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; enable = i[0]; op = OP_MUL;
            #1;
            checks++; if (res2 !== 32'hFFFFFFFF) begin errors++; $display("FAIL hold_result%0d: got %h expected ffffffff", i, res2); end
            checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL hold_ready%0d: got %b expected 1", i, rdy2); end
        end
        @(negedge clk);
        enable = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        ex_ready = 1'b0;
        checks++; if (mc2 !== 1'b0 || rdy2 !== 1'b1) begin errors++; $display("FAIL idle_after_release: got mc=%b rdy=%b expected mc=0 rdy=1", mc2, rdy2); end
        op = OP_MULH; ss = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; enable = 1'b1;
        #1;
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL idle_enable_ready: got %b expected 0", rdy2); end
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        checks++; if (mc2 !== 1'b1) begin errors++; $display("FAIL b2b_multicycle: got %b expected 1", mc2); end
        lat = 1;
        while (!rdy2 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (res2 !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_result: got %h expected fffffffe", res2); end
        checks++; if (lat !== MULH_LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, MULH_LAT); end
        release_done();
    endtask

    task automatic test_reset_mid_calc;
        int lat; logic [31:0] r;
        @(negedge clk);
        op = OP_MULH; ss = 2'b00; a = 32'd9; b = 32'd9; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (res2 !== 32'd0) begin errors++; $display("FAIL midreset_result: got %h expected 00000000", res2); end
        checks++; if (mc2 !== 1'b0) begin errors++; $display("FAIL midreset_multicycle: got %b expected 0", mc2); end
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", rdy2); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MUL, 2'b00, 32'd3, 32'd5, lat, r);
        checks++; if (r !== 32'h0000000F) begin errors++; $display("FAIL post_reset_mul: got %h expected 0000000f", r); end
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, MUL_LAT); end
        release_done();
    endtask

    task automatic test_illegal_op;
        int lat; logic [31:0] r;
        run_op(OP_BAD, 2'b00, 32'd5, 32'd5, lat, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL illegal_result: got %h expected 00000000", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency: got %0d expected 1", lat); end
        release_done();
    endtask

    task automatic test_fast_low;
        int lat; logic [31:0] r;
        run_op(OP_MUL, 2'b00, 32'h00010000, 32'h00010000, lat, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL fast_mul_result: got %h expected 00000000", r); end
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL fast_mul_latency: got %0d expected %0d", lat, MUL_LAT); end
        release_done();
        run_op(OP_MULH, 2'b00, 32'h00010000, 32'h00010000, lat, r);
        checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL fast_mulh_result: got %h expected 00000001", r); end
        checks++; if (lat !== MULH_LAT) begin errors++; $display("FAIL fast_mulh_latency: got %0d expected %0d", lat, MULH_LAT); end
        release_done();
    endtask

    task automatic test_width_sweep;
        int cyc; int l1; int l2; int l4; int l8;
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; ex_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        op = OP_MULH; ss = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        l1 = 0; l2 = 0; l4 = 0; l8 = 0;
        cyc = 1;
        while (cyc <= 40) begin
            if (rdy1 && l1 == 0) l1 = cyc;
            if (rdy2 && l2 == 0) l2 = cyc;
            if (rdy4 && l4 == 0) l4 = cyc;
            if (rdy8 && l8 == 0) l8 = cyc;
            @(negedge clk);
            cyc++;
        end
        checks++; if (l1 !== 33) begin errors++; $display("FAIL sweep_lat_b1: got %0d expected 33", l1); end
        checks++; if (l2 !== 17) begin errors++; $display("FAIL sweep_lat_b2: got %0d expected 17", l2); end
        checks++; if (l4 !== 9) begin errors++; $display("FAIL sweep_lat_b4: got %0d expected 9", l4); end
        checks++; if (l8 !== 5) begin errors++; $display("FAIL sweep_lat_b8: got %0d expected 5", l8); end
        checks++; if (res1 !== 32'hFFFFFFFE) begin errors++; $display("FAIL sweep_res_b1: got %h expected fffffffe", res1); end
        checks++; if (res2 !== 32'hFFFFFFFE) begin errors++; $display("FAIL sweep_res_b2: got %h expected fffffffe", res2); end
        checks++; if (res4 !== 32'hFFFFFFFE) begin errors++; $display("FAIL sweep_res_b4: got %h expected fffffffe", res4); end
        checks++; if (res8 !== 32'hFFFFFFFE) begin errors++; $display("FAIL sweep_res_b8: got %h expected fffffffe", res8); end
        release_done();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_hold_and_back_to_back();
        test_reset_mid_calc();
        test_illegal_op();
        test_fast_low();
        test_width_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/mult_seq_responder.md
Name: mult_seq_responder

Overview:
- Iterative integer multiplier that implements the responder side of the MUL/MULH handshake used by the EX-stage multiplier agent.
- Accepts MUL_MAC32 (mul) and MUL_H (mulh/mulhsu/mulhu) operations from the EX stage.
- Computes them with a radix-2^BITS_PER_CYCLE shift-add datapath, and holds the result until the EX stage signals ready.
- Serves as a multicycle reference responder and as an area-reduced multiplier option.

Parameters:
- BITS_PER_CYCLE, 2, op_b bits consumed per step; legal values 1, 2, 4, 8; STEPS = 32/BITS_PER_CYCLE.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- enable_i  in  1  request valid from EX stage
- operator_i  in  3  mul_opcode_e; MUL_MAC32=3'b000, MUL_H=3'b110
- short_signed_i  in  2  [0]=op_a signed, [1]=op_b signed; 11 mulh, 01 mulhsu, 00 mulhu
- op_a_i  in  32  operand a (rs1)
- op_b_i  in  32  operand b (rs2)
- ex_ready_i  in  1  EX stage consumes result
- result_o  out  32  product: low word for MUL_MAC32, high word for MUL_H
- ready_o  out  1  result valid / block able to accept
- multicycle_o  out  1  high while in CALC

Behaviour:
- Reset values: state=IDLE, result_o=0, multicycle_o=0, internal regs 0. ready_o is combinational: (IDLE & !enable_i) | DONE, so it is 1 under reset when enable_i=0.
- FSM IDLE:
  - enable_i=1 with a legal operator: accept. Latch sign-adjusted magnitudes of a and b; sign_a = short_signed_i[0]&op_a_i[31], sign_b = short_signed_i[1]&op_b_i[31]. Latch neg = sign_a^sign_b, the operator, acc=0 and step count=0. Go to CALC.
  - Illegal operator: go to DONE with result_o=0.
- FSM CALC:
  - Each cycle: acc += mag_a * mag_b[BITS_PER_CYCLE-1:0], positioned at bit offset count*BITS_PER_CYCLE in a 64-bit accumulator. Then mag_b >>= BITS_PER_CYCLE and count++.
  - On the step where count reaches STEPS-1: form p = neg ? -acc : acc (64-bit two's complement). result_o <= MUL_H ? p[63:32] : p[31:0]. Go to DONE.
- FSM DONE:
  - ready_o=1 and result_o is stable.
  - ex_ready_i=1: go to IDLE. The next enable_i is treated as a new request.
  - ex_ready_i=0: stay in DONE. Input changes are ignored.
- Latency: enable_i sampled in IDLE at edge 0; ready_o goes high in the cycle after edge STEPS, which is 17 cycles for the default.
- Inputs are sampled only in IDLE; operand changes during CALC/DONE have no effect.
- ready_o=0 throughout CALC, and in IDLE while enable_i=1.
- Reset asserted mid-CALC or mid-DONE: asynchronous return to IDLE, result_o=0. The partial result is discarded with no residual effect.
- Width: magnitudes are 32-bit unsigned, so |-2^31| = 0x80000000. The 64-bit product magnitude is < 2^63, so negation cannot overflow.

Optional Feature:
- Macro: MULT_FAST_LOW_EN.
- Defined: MUL_MAC32 bypasses CALC. The accept cycle computes the low 32 bits of op_a_i*op_b_i combinationally, registers the value to result_o and goes to DONE, so ready_o is high one cycle after accept. MUL_H is unchanged.
- Undefined: all operators use the iterative path.

Decomposition:
- Shared package: mul_opcode_e and MUL_OP_WIDTH=3, in the existing core package (not duplicated); the short_signed encoding constants (MULH=2'b11, MULHSU=2'b01, MULHU=2'b00).
- Local to the module: the state enum (IDLE, CALC, DONE).
- Natural sub-module: mult_seq_step, a combinational 32 x BITS_PER_CYCLE partial product plus 64-bit accumulate.

Test Plan:
- MUL_MAC32, a=7, b=6 -> result_o=0x0000002A; ready_o rises exactly 17 cycles after accept (BITS_PER_CYCLE=2).
- MUL_H ss=11, a=0x80000000, b=0x80000000 -> 0x40000000; ss=11, a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF.
- MUL_H ss=01, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; ss=00, same operands -> 0xFFFFFFFE.
- DONE with ex_ready_i=0 for 5 cycles while op_a_i/op_b_i toggle -> result_o and ready_o unchanged. ex_ready_i=1 -> IDLE next cycle; back-to-back request accepted.
- rst_n pulsed low at CALC step 8 -> immediately IDLE, result_o=0, multicycle_o=0. A following MUL 3*5 -> 0x0000000F with full latency.
- With MULT_FAST_LOW_EN: MUL 0x10000*0x10000 -> 0x00000000, ready 1 cycle after accept; MUL_H is still 17 cycles. Sweep BITS_PER_CYCLE 1/4/8 -> latency 33/9/5.
